// File: rtl/instr_fetch.sv
// Instruction fetch stage: a small IDLE/RUN/DONE sequencer that walks the
// program counter, latches the fetched instruction and handles jumps and halt.
module instr_fetch #(
    parameter int             PW   = 10,
    parameter int             IW   = 9,
    parameter logic [IW-1:0]  HALT = IW'(9'h1FF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          uncd_jmp,
    input  logic          br_taken,
    input  logic [PW-1:0] target,
    output logic [PW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] ir,
    output logic [3:0]    opcode,
    output logic          ir_valid,
    output logic [PW-1:0] pc,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          done_q, done_d;

    logic running;
    logic halt_hit;
    logic redirect;

    assign running  = (state_q == S_RUN) & ~stall;
    // Halt is checked ahead of redirect so a jump sharing the HALT cycle loses.
    assign halt_hit = running & ir_valid_q & (ir_q == HALT);
    assign redirect = running & ir_valid_q & (uncd_jmp | br_taken);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        done_d     = done_q;

        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    pc_d       = '0;
                    ir_valid_d = 1'b0;
                    done_d     = 1'b0;
                    if (start) begin
                        state_d = S_RUN;
                    end
                end

                S_RUN: begin
                    if (halt_hit) begin
                        state_d    = S_DONE;
                        ir_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (redirect) begin
                        // The fetch made this cycle is squashed: one-cycle bubble.
                        pc_d       = target;
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = imem_data;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + PW'(1);
                    end
                end

                S_DONE: begin
                    done_d = 1'b1;
                    if (start) begin
                        state_d    = S_RUN;
                        pc_d       = '0;
                        ir_valid_d = 1'b0;
                        done_d     = 1'b0;
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    pc_d       = '0;
                    ir_valid_d = 1'b0;
                    done_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            done_q     <= done_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[IW-1:IW-4];
    assign ir_valid  = ir_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized traffic, all
// compared against a program-level model of the fetch sequencer.
module tb_instr_fetch;

    localparam int             PW   = 10;
    localparam int             IW   = 9;
    localparam logic [IW-1:0]  HALT = 9'h1FF;
    localparam int             MSZ  = 1 << PW;

    logic          clk = 1'b0;
    logic          reset, start, stall, uncd_jmp, br_taken;
    logic [PW-1:0] target, imem_addr, pc;
    logic [IW-1:0] imem_data, ir;
    logic [3:0]    opcode;
    logic          ir_valid, done;

    logic [IW-1:0] mem [MSZ];

    int checks = 0;
    int errs   = 0;

    // Model: "active" = program executing, "halted" = program ended.
    bit            m_active, m_halted;
    int            m_pc;
    logic [IW-1:0] m_ir;
    bit            m_valid;

    instr_fetch #(.PW(PW), .IW(IW), .HALT(HALT)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .uncd_jmp(uncd_jmp), .br_taken(br_taken), .target(target),
        .imem_addr(imem_addr), .imem_data(imem_data), .ir(ir),
        .opcode(opcode), .ir_valid(ir_valid), .pc(pc), .done(done)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_halted = 0; m_pc = 0; m_ir = '0; m_valid = 0;
    endtask

    // Applied at each rising edge using the inputs held across that edge.
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (!stall) begin
            if (!m_active && !m_halted) begin
                if (start) begin m_active = 1; m_pc = 0; end
            end else if (m_halted) begin
                if (start) begin m_halted = 0; m_active = 1; m_pc = 0; m_valid = 0; end
            end else if (m_valid && m_ir == HALT) begin
                m_active = 0; m_halted = 1; m_valid = 0;
            end else if (m_valid && (uncd_jmp || br_taken)) begin
                m_pc = int'(target); m_valid = 0;
            end else begin
                m_ir = mem[m_pc]; m_valid = 1; m_pc = (m_pc + 1) % MSZ;
            end
        end
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("done", 32'(done), 32'(m_halted));
        if (m_valid || m_halted) begin
            chk("ir", 32'(ir), 32'(m_ir));
            chk("opcode", 32'(opcode), 32'(m_ir[IW-1:IW-4]));
        end
    endtask

    task automatic drive(input bit st, input bit sl, input bit uj, input bit bt, input logic [PW-1:0] tg);
        start = st; stall = sl; uncd_jmp = uj; br_taken = bt; target = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Reset raised between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        model_step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_valid", 32'(ir_valid), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] hold_pc;
        logic [IW-1:0] hold_ir;

        for (int i = 0; i < MSZ; i++) begin
            logic [IW-1:0] v;
            v = IW'($urandom_range(0, 510));
            mem[i] = v;
        end
        mem[0] = 9'h010; mem[1] = 9'h020; mem[2] = 9'h030; mem[3] = HALT;

        reset = 1'b1;
        drive(0, 0, 0, 0, '0);
        model_reset();
        repeat (2) tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential program ending in HALT.
        drive(1, 0, 0, 0, '0); tick();
        drive(0, 0, 0, 0, '0); tick();
        chk("seq_ir0", 32'(ir), 32'h010);
        tick(); chk("seq_ir1", 32'(ir), 32'h020);
        tick(); chk("seq_ir2", 32'(ir), 32'h030);
        tick(); chk("seq_ir3", 32'(ir), 32'h1FF);
        tick(); chk("seq_done", 32'(done), 32'd1);
        chk("seq_pc", 32'(pc), 32'd4);
        tick(); chk("seq_pc_frozen", 32'(pc), 32'd4);

        // Restart from DONE.
        drive(1, 0, 0, 0, '0); tick();
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_pc", 32'(pc), 32'd0);
        drive(0, 0, 0, 0, '0);
        tick(); chk("rs_ir0", 32'(ir), 32'h010);
        repeat (5) tick();
        chk("rs_done2", 32'(done), 32'd1);

        // Jump from pc 5 with no HALT in the way.
        mem[3] = 9'h031;
        reset = 1'b1; tick(); @(negedge clk); reset = 1'b0;
        drive(1, 0, 0, 0, '0); tick();
        drive(0, 0, 0, 0, '0); repeat (5) tick();
        chk("jmp_pre_pc", 32'(pc), 32'd5);
        chk("jmp_pre_valid", 32'(ir_valid), 32'd1);
        drive(0, 0, 1, 0, 10'h040); tick();
        chk("jmp_pc", 32'(pc), 32'h040);
        chk("jmp_bubble", 32'(ir_valid), 32'd0);
        drive(0, 0, 1, 0, 10'h123); tick();
        chk("jmp_ir", 32'(ir), 32'(mem[10'h040]));
        chk("jmp_valid", 32'(ir_valid), 32'd1);

        // Stall overrides a pending branch for 3 cycles.
        hold_pc = pc; hold_ir = ir;
        drive(1, 1, 0, 1, 10'h100);
        repeat (3) begin
            tick();
            chk("stall_pc", 32'(pc), 32'(hold_pc));
            chk("stall_ir", 32'(ir), 32'(hold_ir));
            chk("stall_valid", 32'(ir_valid), 32'd1);
        end
        drive(0, 0, 0, 1, 10'h100); tick();
        chk("stall_redirect", 32'(pc), 32'h100);

        // Wrap at the top of the address space.
        drive(0, 0, 0, 0, '0); tick();
        drive(0, 0, 1, 0, 10'h3FF); tick();
        chk("wrap_pre", 32'(pc), 32'h3FF);
        drive(0, 0, 0, 0, '0); tick();
        chk("wrap_pc", 32'(pc), 32'd0);

        // Asynchronous reset mid-run at pc 7.
        repeat (7) tick();
        chk("ar_pre_pc", 32'(pc), 32'd7);
        async_reset();
        repeat (3) tick();
        chk("ar_idle_pc", 32'(pc), 32'd0);
        chk("ar_idle_valid", 32'(ir_valid), 32'd0);

        // Randomized traffic with sprinkled HALTs.
        for (int i = 0; i < MSZ; i++) begin
            if ($urandom_range(0, 31) == 0) mem[i] = HALT;
        end
        for (int c = 0; c < 3000; c++) begin
            drive(bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 4) == 0),
                  bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) == 0),
                  PW'($urandom));
            if ($urandom_range(0, 299) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PW, default 10, meaning program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter IW, default 9, meaning instruction width.
REQ-003 The block SHALL have parameter HALT, default 9'h1FF, meaning the instruction encoding that ends a program.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: begins a program at address 0 when the block is not running.
REQ-007 Port stall, input, 1: holds all fetch state for the cycle.
REQ-008 Port uncd_jmp, input, 1: unconditional jump, driven by the control decoder UncdJmp output.
REQ-009 Port br_taken, input, 1: conditional jump resolved taken.
REQ-010 Port target, input, PW: absolute jump/branch destination.
REQ-011 Port imem_addr, output, PW: instruction-memory read address, equal to pc.
REQ-012 Port imem_data, input, IW: instruction-memory data, combinational from imem_addr.
REQ-013 Port ir, output, IW: registered current instruction.
REQ-014 Port opcode, output, 4: ir[IW-1:IW-4], feeding the control decoder instr input.
REQ-015 Port ir_valid, output, 1: ir holds a live instruction.
REQ-016 Port pc, output, PW: current fetch address.
REQ-017 Port done, output, 1: program has halted.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-019 IDLE: pc=0, ir_valid=0, done=0; start=1 SHALL move to RUN next cycle with pc=0.
REQ-020 RUN, stall=0, no redirect: ir<=imem_data, ir_valid<=1, pc<=pc+1 modulo 2^PW (all-ones wraps to 0).
REQ-021 redirect SHALL be ir_valid & (uncd_jmp | br_taken) & ~stall & state==RUN.
REQ-022 On redirect: pc<=target and ir_valid<=0, squashing the fetch made that cycle (one-cycle bubble); ir contents are don't-care while ir_valid=0.
REQ-023 uncd_jmp/br_taken with ir_valid=0 SHALL be ignored.
REQ-024 stall=1 SHALL freeze pc, ir, ir_valid and state; stall overrides redirect, halt detection and start.
REQ-025 Halt: in RUN with ir_valid=1, ir==HALT and stall=0 SHALL move to DONE next cycle; pc and ir frozen, ir_valid<=0, done<=1.
REQ-026 A redirect in the same cycle as ir==HALT SHALL NOT occur by ISA; halt takes priority if it does.
REQ-027 DONE: done held at 1; start=1 SHALL restart in RUN with pc=0, done<=0, ir_valid<=0.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 Fetch-to-ir latency SHALL be exactly one cycle; first valid ir appears two cycles after start is sampled.
REQ-030 opcode and imem_addr SHALL be purely combinational from ir and pc.

Reset
REQ-031 reset=1 SHALL asynchronously force state=IDLE, pc=0, ir=0, ir_valid=0, done=0, regardless of clk or stall.
REQ-032 reset asserted mid-RUN SHALL discard the pending fetch; after release, the block SHALL wait in IDLE for start.

Verification
REQ-033 Sequential run: imem[0..3]=9'h010,9'h020,9'h030,HALT; start pulse -> ir_valid rises, ir shows 010,020,030,1FF on consecutive cycles, then done=1, pc frozen at 4.
REQ-034 Jump: ir valid at pc 5 with uncd_jmp=1, target=10'h040 -> next cycle pc=040, ir_valid=0; following cycle ir=imem[040], ir_valid=1.
REQ-035 Stall priority: stall=1 with br_taken=1 for 3 cycles -> pc, ir, ir_valid unchanged; redirect occurs on the first stall=0 cycle.
REQ-036 Wrap: pc=10'h3FF, no redirect -> next pc=0.
REQ-037 Async reset: assert reset between clock edges mid-RUN at pc=7 -> pc=0, ir_valid=0, done=0 immediately; start required to resume.
REQ-038 Restart: in DONE, pulse start -> done=0, pc=0, program re-executes from address 0.
